muxn_reg: RTL and testbench

- Parametrised successor to the 2:1 select primitive: an N-channel, W-bit multiplexer with a registered output stage.
- Per-channel valid/ack handshakes on the input side and a valid/ready handshake on the output side.
- Two select modes, switchable at run time:
  - direct: a binary select port picks the channel.
  - round-robin: internal arbitration picks the channel.
- Sits between datapath sources (ALU result, load data, immediate, PC+4, ...) and write-back / downstream pipeline registers.

---
 rtl/muxn_pkg.sv | 10 +
 rtl/rr_pick.sv | 31 +++
 rtl/muxn_reg.sv | 106 ++++++++++
 tb/tb_muxn_reg.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/muxn_pkg.sv
// Shared constants for the N-channel registered multiplexer.
// Select-mode encodings and the stall counter width.
package muxn_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority finder: first set request at or after ptr,
// wrapping modulo CHANNELS (correct for non-power-of-2 counts).
module rr_pick #(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] reqs,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    grant,
  output logic                grantValid
);

  int idx;

  // Walk farthest-to-nearest so the nearest request is written last.
  always_comb begin
    grant      = '0;
    grantValid = 1'b0;
    idx        = 0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= CHANNELS)
        idx = idx - CHANNELS;
      if (reqs[idx]) begin
        grant      = SEL_W'(idx);
        grantValid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/muxn_reg.sv
// N-channel W-bit mux with registered output, direct or round-robin select.
// Optional stall counter port when MUXN_REG_STALL_CNT_EN is defined.
module muxn_reg
  import muxn_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      inClk,
  input  logic                      inRst,
  input  logic [CHANNELS*WIDTH-1:0] inData,
  input  logic [CHANNELS-1:0]       inValid,
  output logic [CHANNELS-1:0]       outAck,
  input  logic [SEL_W-1:0]          inSel,
  input  logic                      inMode,
  output logic [WIDTH-1:0]          outData,
  output logic                      outValid,
  input  logic                      inReady,
  output logic [SEL_W-1:0]          outSel
`ifdef MUXN_REG_STALL_CNT_EN
  ,output logic [STALL_CNT_W-1:0]   outStallCnt
`endif
);

  logic             load;
  logic             dirValid;
  logic             rrValid;
  logic             grantValid;
  logic [SEL_W-1:0] rrGrant;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] rrPtr;
  logic [SEL_W-1:0] rrNext;
  logic [WIDTH-1:0] selData;

  assign load = !outValid || inReady;

  // Out-of-range selects count as no request.
  assign dirValid = ({1'b0, inSel} < (SEL_W + 1)'(CHANNELS))
                    && inValid[inSel];

  rr_pick #(
    .CHANNELS(CHANNELS)
  ) uPick (
    .reqs      (inValid),
    .ptr       (rrPtr),
    .grant     (rrGrant),
    .grantValid(rrValid)
  );

  always_comb begin
    grant      = inSel;
    grantValid = dirValid;
    if (inMode == MODE_RR) begin
      grant      = rrGrant;
      grantValid = rrValid;
    end
  end

  // Decoded select keeps unselected channels out of the output path.
  always_comb begin
    selData = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (grant == SEL_W'(i))
        selData = inData[i*WIDTH +: WIDTH];
  end

  always_comb begin
    outAck = '0;
    for (int i = 0; i < CHANNELS; i++)
      outAck[i] = !inRst && load && grantValid
                  && (grant == SEL_W'(i));
  end

  assign rrNext = (grant == SEL_W'(CHANNELS - 1)) ? '0
                : grant + SEL_W'(1);

  always_ff @(posedge inClk) begin
    if (inRst) begin
      outData  <= '0;
      outValid <= 1'b0;
      outSel   <= '0;
      rrPtr    <= '0;
    end else if (load) begin
      if (grantValid) begin
        outData  <= selData;
        outSel   <= grant;
        outValid <= 1'b1;
        if (inMode == MODE_RR)
          rrPtr <= rrNext;
      end else begin
        outValid <= 1'b0;
      end
    end
  end

`ifdef MUXN_REG_STALL_CNT_EN
  always_ff @(posedge inClk) begin
    if (inRst)
      outStallCnt <= '0;
    else if (outValid && !inReady && (outStallCnt != '1))
      outStallCnt <= outStallCnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_muxn_reg.sv
// Randomized bench for muxn_reg against a queue-free reference model.
// Also exercises a CHANNELS=3 instance for the wrap case.
module tb_muxn_reg;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        inRst;
  logic [31:0] inData;
  logic [3:0]  inValid;
  logic [3:0]  outAck;
  logic [1:0]  inSel;
  logic        inMode;
  logic [7:0]  outData;
  logic        outValid;
  logic        inReady;
  logic [1:0]  outSel;

  logic        rst3;
  logic [23:0] data3;
  logic [2:0]  valid3;
  logic [2:0]  ack3;
  logic [1:0]  sel3;
  logic        mode3;
  logic [7:0]  out3Data;
  logic        out3Valid;
  logic        ready3;
  logic [1:0]  out3Sel;

`ifdef MUXN_REG_STALL_CNT_EN
  logic [15:0] stallCnt;
  logic [15:0] stall3;
`endif

  muxn_reg #(.WIDTH(8), .CHANNELS(4)) dut (
    .inClk   (clk),
    .inRst   (inRst),
    .inData  (inData),
    .inValid (inValid),
    .outAck  (outAck),
    .inSel   (inSel),
    .inMode  (inMode),
    .outData (outData),
    .outValid(outValid),
    .inReady (inReady),
    .outSel  (outSel)
`ifdef MUXN_REG_STALL_CNT_EN
    ,.outStallCnt(stallCnt)
`endif
  );

  muxn_reg #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .inClk   (clk),
    .inRst   (rst3),
    .inData  (data3),
    .inValid (valid3),
    .outAck  (ack3),
    .inSel   (sel3),
    .inMode  (mode3),
    .outData (out3Data),
    .outValid(out3Valid),
    .inReady (ready3),
    .outSel  (out3Sel)
`ifdef MUXN_REG_STALL_CNT_EN
    ,.outStallCnt(stall3)
`endif
  );

  int nChecks = 0;
  int nPass   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model state
  bit       mValid;
  bit [7:0] mData;
  int       mSel;
  int       mPtr;
  int       mStall;

  task automatic step(input logic r, input logic m,
                      input logic [1:0] s, input logic [3:0] v,
                      input logic [31:0] d, input logic rdy);
    bit load;
    bit gv;
    int g;
    @(negedge clk);
    inRst = r; inMode = m; inSel = s;
    inValid = v; inData = d; inReady = rdy;
    #1;
    load = !mValid || rdy;
    gv = 0;
    g = 0;
    if (!m) begin
      g = s;
      gv = (g < 4) && v[g];
    end else begin
      for (int k = 0; k < 4 && !gv; k++)
        if (v[(mPtr + k) % 4]) begin
          g = (mPtr + k) % 4;
          gv = 1;
        end
    end
    chk("ack", outAck, (!r && load && gv) ? (32'd1 << g) : 32'd0);
    if (r) begin
      mValid = 0; mData = 0; mSel = 0; mPtr = 0; mStall = 0;
    end else begin
      if (mValid && !rdy && mStall < 65535) mStall++;
      if (load) begin
        if (gv) begin
          mData = d[g*8 +: 8];
          mSel = g;
          mValid = 1;
          if (m) mPtr = (g + 1) % 4;
        end else begin
          mValid = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("valid", outValid, mValid);
    chk("data", outData, mData);
    chk("sel", outSel, mSel);
`ifdef MUXN_REG_STALL_CNT_EN
    chk("stall", stallCnt, mStall);
`endif
  endtask

  int exp3[4] = '{0, 1, 2, 0};

  initial begin
    inRst = 1; inMode = 0; inSel = 0; inValid = 0;
    inData = 0; inReady = 0;
    rst3 = 1; mode3 = 1; sel3 = 0; valid3 = 0;
    data3 = 24'h332211; ready3 = 1;

    // Reset state
    step(1, 0, 0, 4'b1111, 32'hFFFFFFFF, 1);
    chk("rst_valid", outValid, 0);
    chk("rst_data", outData, 0);

    // Direct select of channel 2
    step(0, 0, 2, 4'b0100, 32'h00C30000, 1);
    chk("dir_data", outData, 8'hC3);
    chk("dir_sel", outSel, 2);
    chk("dir_valid", outValid, 1);

    // Direct select of a non-requesting channel
    step(0, 0, 1, 4'b0100, 32'h00C30000, 1);
    chk("dir_inv_valid", outValid, 0);

    // Backpressure hold after a fresh reset
    step(1, 0, 0, 4'b0000, 32'h0, 1);
    step(0, 0, 0, 4'b0001, 32'h00000011, 1);
    for (int i = 0; i < 3; i++)
      step(0, i[0], 2'(i + 1), 4'($urandom), $urandom, 0);
    chk("hold_data", outData, 8'h11);
`ifdef MUXN_REG_STALL_CNT_EN
    chk("hold_cnt", stallCnt, 3);
`endif

    // Reset while stalled on 8'h5A
    step(0, 0, 3, 4'b1000, 32'h5A000000, 1);
    step(0, 0, 3, 4'b1000, 32'h5A000000, 0);
    chk("stall_data", outData, 8'h5A);
    step(1, 0, 3, 4'b1111, 32'h5A5A5A5A, 0);
    chk("rstmid_valid", outValid, 0);
    chk("rstmid_data", outData, 0);
    chk("rstmid_sel", outSel, 0);

    // Round-robin fairness
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 4'b1111, 32'h44332211, 1);
      chk("rr_fair", outSel, i % 4);
    end

    // Skip and wrap from rr_ptr=1
    step(0, 1, 0, 4'b1001, 32'hD0B0A090, 1);
    chk("rr_skip0", outSel, 3);
    step(0, 1, 0, 4'b1001, 32'hD0B0A090, 1);
    chk("rr_skip1", outSel, 0);
    step(0, 1, 0, 4'b1001, 32'hD0B0A090, 1);
    chk("rr_skip2", outSel, 3);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 29) == 0), 1'($urandom),
           2'($urandom), 4'($urandom), $urandom,
           ($urandom_range(0, 3) != 0));

    // Three-channel wrap
    @(negedge clk);
    rst3 = 1;
    @(negedge clk);
    rst3 = 0; valid3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr3_ack", ack3, 32'd1 << exp3[i]);
      @(posedge clk);
      #1;
      chk("rr3_sel", out3Sel, exp3[i]);
      chk("rr3_data", out3Data, 8'h11 * (exp3[i] + 1));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
